// File: rtl/servo_pkg.sv
// servo_pkg -- shared definitions for the AXI4-Lite servo PWM block.
//   Register offsets and word indices, field widths, register reset values,
//   the AXI OKAY response code, the register-file struct and the byte-lane
//   merge helper used by the write path.
package servo_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 32;

    // Byte offsets of the four 32-bit registers.
    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_PERIOD  = 4'h4;
    localparam logic [3:0] OFF_DUTY    = 4'h8;
    localparam logic [3:0] OFF_SCRATCH = 4'hC;

    // Word index (addr[3:2]) of each register.
    localparam logic [1:0] IDX_CTRL    = OFF_CTRL[3:2];
    localparam logic [1:0] IDX_PERIOD  = OFF_PERIOD[3:2];
    localparam logic [1:0] IDX_DUTY    = OFF_DUTY[3:2];
    localparam logic [1:0] IDX_SCRATCH = OFF_SCRATCH[3:2];

    // CTRL fields.
    localparam int unsigned CTRL_EN_BIT = 0;

    // Register reset values.
    localparam logic [DATA_W-1:0] CTRL_RST    = 32'h0000_0000;
    localparam logic [DATA_W-1:0] PERIOD_RST  = 32'h0000_0000;
    localparam logic [DATA_W-1:0] DUTY_RST    = 32'h0000_0000;
    localparam logic [DATA_W-1:0] SCRATCH_RST = 32'h0000_0000;

    // AXI response code.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [DATA_W-1:0] ctrl;
        logic [DATA_W-1:0] period;
        logic [DATA_W-1:0] duty;
        logic [DATA_W-1:0] scratch;
    } regs_t;

    // Merge new_v into old_v one byte lane at a time, taking only the lanes
    // whose strobe bit is set.
    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_pwm_core.sv
// servo_pwm_core -- PWM counter with period/duty shadow registers.
//   clk, rst_n       : clock, synchronous active-low reset
//   enable           : run the counter (CTRL bit 0)
//   period_in/duty_in: live PERIOD / DUTY register values
//   servo_pwm        : enable AND (cnt < shadow duty), forced low when period is 0
//   period_tick      : one-cycle pulse at every wrap while enabled
// Both outputs are registered, so they trail the counter state by one cycle;
// pulse shape and tick spacing are unaffected.
module servo_pwm_core
    import servo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] duty_in,
    output logic             servo_pwm,
    output logic             period_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             pwm_q, pwm_d;
    logic             tick_q, tick_d;
    logic             wrap_s;

    // Wrap detection; a period of 0 or 1 wraps every cycle so cnt stays at 0.
    always_comb begin
        wrap_s = 1'b0;
        if (per_sh_q <= 32'd1) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = (cnt_q >= (per_sh_q - 32'd1));
        end
    end

    // Counter and shadow next state: shadows track the registers while
    // disabled and otherwise reload only at the wrap.
    always_comb begin
        cnt_d     = cnt_q;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        if (!enable) begin
            cnt_d     = 32'd0;
            per_sh_d  = period_in;
            duty_sh_d = duty_in;
        end else if (wrap_s) begin
            cnt_d     = 32'd0;
            per_sh_d  = period_in;
            duty_sh_d = duty_in;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Output next state.
    always_comb begin
        pwm_d  = enable && (per_sh_q != 32'd0) && (cnt_q < duty_sh_q);
        tick_d = enable && wrap_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 32'd0;
            per_sh_q  <= 32'd0;
            duty_sh_q <= 32'd0;
            pwm_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
            pwm_q     <= pwm_d;
            tick_q    <= tick_d;
        end
    end

    assign servo_pwm   = pwm_q;
    assign period_tick = tick_q;

endmodule

// File: rtl/servo_pwm_axil.sv
// servo_pwm_axil -- AXI4-Lite slave with CTRL/PERIOD/DUTY/SCRATCH registers
// driving a servo PWM generator.
//   s00_axi_aclk / s00_axi_aresetn : clock, synchronous active-low reset
//   s00_axi_aw* / w* / b*          : write address, data, response channels
//   s00_axi_ar* / r*               : read address and data channels
//   servo_pwm                      : servo pulse output
//   period_tick                    : one-cycle pulse per PWM period
// AW and W are latched independently; the register is written once both are
// held, and nothing new is accepted until the B handshake.
module servo_pwm_axil
    import servo_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            servo_pwm,
    output logic                            period_tick
);

    regs_t             regs_q, regs_d;
    logic              aw_full_q, aw_full_d;
    logic [1:0]        aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, wr_fire_s;
    logic [DATA_W-1:0] rd_mux_s;
    logic              unused_s;

    // Protection bits and the byte-offset address bits carry no meaning here.
    assign unused_s = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    // Channel handshakes; the write fires once both latches hold data.
    always_comb begin
        aw_hs_s   = s00_axi_awvalid && awready_q;
        w_hs_s    = s00_axi_wvalid && wready_q;
        b_hs_s    = bvalid_q && s00_axi_bready;
        ar_hs_s   = s00_axi_arvalid && arready_q;
        r_hs_s    = rvalid_q && s00_axi_rready;
        wr_fire_s = aw_full_q && w_full_q && !bvalid_q;
    end

    // Write-channel latches, response and ready next state.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (b_hs_s) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b0;
        end else if (wr_fire_s) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
        end else begin
            if (aw_hs_s) begin
                aw_full_d = 1'b1;
                aw_idx_d  = s00_axi_awaddr[3:2];
            end else begin
                aw_full_d = aw_full_q;
            end
            if (w_hs_s) begin
                w_full_d = 1'b1;
                w_data_d = s00_axi_wdata;
                w_strb_d = s00_axi_wstrb;
            end else begin
                w_full_d = w_full_q;
            end
        end
        // Readies are registered from the next state so they are low in reset.
        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;
    end

    // Register file update with byte-lane gating.
    always_comb begin
        regs_d = regs_q;
        if (wr_fire_s) begin
            case (aw_idx_q)
                IDX_CTRL:    regs_d.ctrl    = apply_wstrb(regs_q.ctrl, w_data_q, w_strb_q);
                IDX_PERIOD:  regs_d.period  = apply_wstrb(regs_q.period, w_data_q, w_strb_q);
                IDX_DUTY:    regs_d.duty    = apply_wstrb(regs_q.duty, w_data_q, w_strb_q);
                IDX_SCRATCH: regs_d.scratch = apply_wstrb(regs_q.scratch, w_data_q, w_strb_q);
                default:     regs_d         = regs_q;
            endcase
        end else begin
            regs_d = regs_q;
        end
    end

    // Read mux on the pre-write register values, so a same-cycle write is not seen.
    always_comb begin
        case (s00_axi_araddr[3:2])
            IDX_CTRL:    rd_mux_s = regs_q.ctrl;
            IDX_PERIOD:  rd_mux_s = regs_q.period;
            IDX_DUTY:    rd_mux_s = regs_q.duty;
            IDX_SCRATCH: rd_mux_s = regs_q.scratch;
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Read-channel next state.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux_s;
            rresp_d  = RESP_OKAY;
        end else if (r_hs_s) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
        arready_d = !rvalid_d;
    end

    // State register; reset drops any half-accepted transaction.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            regs_q    <= '{ctrl: CTRL_RST, period: PERIOD_RST, duty: DUTY_RST, scratch: SCRATCH_RST};
            aw_full_q <= 1'b0;
            aw_idx_q  <= 2'd0;
            w_full_q  <= 1'b0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
        end else begin
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;

    servo_pwm_core u_core (
        .clk         (s00_axi_aclk),
        .rst_n       (s00_axi_aresetn),
        .enable      (regs_q.ctrl[CTRL_EN_BIT]),
        .period_in   (regs_q.period),
        .duty_in     (regs_q.duty),
        .servo_pwm   (servo_pwm),
        .period_tick (period_tick)
    );

endmodule

// File: tb/tb_servo_pwm_axil.sv
// tb_servo_pwm_axil -- directed bench for servo_pwm_axil.
module tb_servo_pwm_axil;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        servo_pwm;
    logic        period_tick;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    servo_pwm_axil dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .servo_pwm       (servo_pwm),
        .period_tick     (period_tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_hs;
        logic w_hs;
        bit   got;
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        resp    = 2'b11;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        if (awvalid || wvalid) begin
            check_eq("aw_w_accept_timeout", 32'd0, 32'd1);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
        bready = 1'b1;
        got    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin
                got  = 1'b1;
                resp = bresp;
            end
            step();
        end
        bready = 1'b0;
        if (!got) check_eq("bvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit got;
        araddr  = addr;
        arvalid = 1'b1;
        data    = 32'hDEAD_BEEF;
        resp    = 2'b11;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (arready) got = 1'b1;
            step();
        end
        arvalid = 1'b0;
        if (!got) check_eq("arready_timeout", 32'd0, 32'd1);
        rready = 1'b1;
        got    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) begin
                got  = 1'b1;
                data = rdata;
                resp = rresp;
            end
            step();
        end
        rready = 1'b0;
        if (!got) check_eq("rvalid_timeout", 32'd0, 32'd1);
    endtask

    // Wait (bounded) for a 0->1 transition of servo_pwm; ends on the first high sample.
    task automatic wait_pwm_rise(input string tag);
        logic prev;
        bit   found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            prev = servo_pwm;
            step();
            if (!prev && servo_pwm) found = 1'b1;
        end
        if (!found) check_eq(tag, 32'd0, 32'd1);
    endtask

    // Count high samples of servo_pwm over n cycles.
    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            if (servo_pwm) highs++;
            step();
        end
    endtask

    logic [31:0] rd_v;
    logic [1:0]  rsp;
    int          len;
    int          highs;
    logic        samp [30];
    int          runs [4];
    int          idx;
    logic        want;
    logic [3:0]  addrs [4];
    logic [31:0] vals  [4];

    initial begin
        aresetn = 1'b0;
        awaddr = 4'h0; awprot = 3'd0; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 4'h0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        addrs[0] = 4'h0; addrs[1] = 4'h4; addrs[2] = 4'h8; addrs[3] = 4'hC;
        vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3; vals[3] = 32'd4;

        // ---- reset state ----
        repeat (3) step();
        check_eq("rst_awready", 32'(awready), 32'd0);
        check_eq("rst_wready", 32'(wready), 32'd0);
        check_eq("rst_arready", 32'(arready), 32'd0);
        check_eq("rst_bvalid", 32'(bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_servo_pwm", 32'(servo_pwm), 32'd0);
        check_eq("rst_period_tick", 32'(period_tick), 32'd0);
        aresetn = 1'b1;
        step();
        check_eq("post_rst_awready", 32'(awready), 32'd1);
        check_eq("post_rst_wready", 32'(wready), 32'd1);
        check_eq("post_rst_arready", 32'(arready), 32'd1);

        // ---- write 1..4 to all registers, read back ----
        for (int i = 0; i < 4; i++) begin
            axi_write(addrs[i], vals[i], 4'hF, rsp);
            check_eq($sformatf("wr_bresp_%0d", i), 32'(rsp), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], rd_v, rsp);
            check_eq($sformatf("rd_data_%0d", i), rd_v, vals[i]);
            check_eq($sformatf("rd_rresp_%0d", i), 32'(rsp), 32'd0);
        end
        axi_write(4'h0, 32'd0, 4'hF, rsp);

        // ---- byte-strobe write on SCRATCH ----
        axi_write(4'hC, 32'h1122_3344, 4'hF, rsp);
        axi_write(4'hC, 32'hAABB_CCDD, 4'b0010, rsp);
        axi_read(4'hC, rd_v, rsp);
        check_eq("wstrb_scratch", rd_v, 32'h1122_CC44);

        // ---- PERIOD=10, DUTY=3 waveform ----
        axi_write(4'h4, 32'd10, 4'hF, rsp);
        axi_write(4'h8, 32'd3, 4'hF, rsp);
        axi_write(4'h0, 32'd1, 4'hF, rsp);
        wait_pwm_rise("p10_rise_timeout");
        len = 0;
        for (int i = 0; i < 40 && servo_pwm; i++) begin
            len++;
            step();
        end
        check_eq("p10_high_len", 32'(len), 32'd3);
        len = 0;
        for (int i = 0; i < 40 && !servo_pwm; i++) begin
            len++;
            step();
        end
        check_eq("p10_low_len", 32'(len), 32'd7);
        for (int i = 0; i < 40 && !period_tick; i++) step();
        check_eq("tick_seen", 32'(period_tick), 32'd1);
        len = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            len++;
            if (period_tick) break;
        end
        check_eq("tick_interval", 32'(len), 32'd10);

        // ---- mid-period DUTY change takes effect at the next period ----
        wait_pwm_rise("duty_chg_rise_timeout");
        fork
            begin
                repeat (2) step();
                axi_write(4'h8, 32'd7, 4'hF, rsp);
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    samp[i] = servo_pwm;
                    step();
                end
            end
        join
        idx = 0;
        for (int r = 0; r < 4; r++) begin
            runs[r] = 0;
            want = (r % 2 == 0) ? 1'b1 : 1'b0;
            while (idx < 30 && samp[idx] == want) begin
                runs[r]++;
                idx++;
            end
        end
        check_eq("chg_cur_high", 32'(runs[0]), 32'd3);
        check_eq("chg_cur_low", 32'(runs[1]), 32'd7);
        check_eq("chg_next_high", 32'(runs[2]), 32'd7);
        check_eq("chg_next_low", 32'(runs[3]), 32'd3);

        // ---- boundary periods and duties ----
        axi_write(4'h4, 32'd4, 4'hF, rsp);
        axi_write(4'h8, 32'd9, 4'hF, rsp);
        repeat (25) step();
        count_high(12, highs);
        check_eq("duty_ge_period_high", 32'(highs), 32'd12);
        axi_write(4'h8, 32'd0, 4'hF, rsp);
        repeat (15) step();
        count_high(12, highs);
        check_eq("duty_zero_low", 32'(highs), 32'd0);
        axi_write(4'h8, 32'd5, 4'hF, rsp);
        axi_write(4'h4, 32'd0, 4'hF, rsp);
        repeat (15) step();
        count_high(12, highs);
        check_eq("period_zero_low", 32'(highs), 32'd0);
        axi_write(4'h4, 32'd1, 4'hF, rsp);
        axi_write(4'h8, 32'd1, 4'hF, rsp);
        repeat (10) step();
        count_high(12, highs);
        check_eq("period_one_high", 32'(highs), 32'd12);
        axi_write(4'h4, 32'd10, 4'hF, rsp);
        axi_write(4'h8, 32'd3, 4'hF, rsp);

        // ---- W three cycles ahead of AW, bready held low ----
        wdata  = 32'h5A5A_0001;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        check_eq("early_w_wready", 32'(wready), 32'd1);
        step();
        wvalid = 1'b0;
        check_eq("early_w_latched", 32'(wready), 32'd0);
        repeat (2) step();
        check_eq("early_w_no_bvalid", 32'(bvalid), 32'd0);
        awaddr  = 4'hC;
        awvalid = 1'b1;
        check_eq("late_aw_awready", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0;
        step();
        check_eq("late_aw_bvalid", 32'(bvalid), 32'd1);
        repeat (4) step();
        check_eq("bhold_bvalid", 32'(bvalid), 32'd1);
        check_eq("bhold_awready", 32'(awready), 32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check_eq("bhs_bvalid_low", 32'(bvalid), 32'd0);
        check_eq("bhs_awready", 32'(awready), 32'd1);
        axi_read(4'hC, rd_v, rsp);
        check_eq("split_write_scratch", rd_v, 32'h5A5A_0001);

        // ---- reset during a half-accepted write while PWM runs ----
        wait_pwm_rise("rst_mid_rise_timeout");
        awaddr  = 4'h8;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        aresetn = 1'b0;
        step();
        check_eq("rstmid_pwm_low", 32'(servo_pwm), 32'd0);
        check_eq("rstmid_bvalid", 32'(bvalid), 32'd0);
        step();
        aresetn = 1'b1;
        step();
        check_eq("rstmid_after_bvalid", 32'(bvalid), 32'd0);
        check_eq("rstmid_after_awready", 32'(awready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], rd_v, rsp);
            check_eq($sformatf("rstmid_reg_%0d", i), rd_v, 32'd0);
        end
        count_high(12, highs);
        check_eq("rstmid_pwm_idle", 32'(highs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
